// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, FSM states and
// the per-opcode flag write mask.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  // Bit order is {N, Z, V}.
  function automatic logic [2:0] nzv_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b010;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer advances only on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_last
);

  logic r_last;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) o_grant = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last <= 1'b1;
    else if (i_accept) r_last <= o_grant[1];
  end

  assign o_last = r_last;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU and keeps
// the architectural N/Z/V flag register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v
);

  state_t            r_state;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_id;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_n, r_z, r_v;

  logic [1:0] w_grant;
  logic       w_accept;
  logic       w_last;
  logic [2:0] w_mask;

  // Readies are masked while reset is held so nothing is accepted during it.
  assign w_accept = (r_state == S_IDLE) && (w_grant != 2'b00) && !rst;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({req1_valid, req0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_last   (w_last)
  );

  assign req0_ready = w_accept && w_grant[0];
  assign req1_ready = w_accept && w_grant[1];

  assign alu_opcode = (r_state == S_EXEC) ? r_op : OP_HLT;
  assign alu_in1    = (r_state == S_EXEC) ? r_a  : '0;
  assign alu_in2    = (r_state == S_EXEC) ? r_b  : '0;

  assign w_mask = nzv_mask(r_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_HLT;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= w_grant[1] ? req1_opcode : req0_opcode;
            r_a     <= w_grant[1] ? req1_a      : req0_a;
            r_b     <= w_grant[1] ? req1_b      : req0_b;
            r_id    <= w_grant[1];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_valid <= 1'b1;
          if (w_mask[2]) r_n <= alu_n;
          if (w_mask[1]) r_z <= alu_z;
          if (w_mask[0]) r_v <= alu_v;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign flag_n    = r_n;
  assign flag_z    = r_z;
  assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small external ALU model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic        alu_n, alu_z, alu_v;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [15:0] rsp_data;
  logic        flag_n, flag_z, flag_v;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(16), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );

  // External ALU model (only the opcodes the bench issues).
  always_comb begin
    alu_out = 16'h0000;
    alu_v   = 1'b0;
    case (alu_opcode)
      4'b0000: begin
        alu_out = alu_in1 + alu_in2;
        alu_v   = (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]);
      end
      4'b0001: begin
        alu_out = alu_in1 - alu_in2;
        alu_v   = (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]);
      end
      4'b0010: alu_out = alu_in1 ^ alu_in2;
      4'b1010: alu_out = {alu_in1[15:8], alu_in2[7:0]};
      default: alu_out = 16'h0000;
    endcase
    alu_n = alu_out[15];
    alu_z = (alu_out == 16'h0000);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_opcode = 4'b0000; req1_opcode = 4'b0000;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    step(); step();
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0000/0", rsp_data, rsp_id); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {flag_n, flag_z, flag_v}); end
    checks++; if (alu_opcode !== 4'hF || alu_in1 !== 16'h0 || alu_in2 !== 16'h0) begin errors++; $display("FAIL reset_alu got=%h %h %h exp=f 0 0", alu_opcode, alu_in1, alu_in2); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    req0_opcode = 4'b0000; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL add_ready got=%b exp=01", {req1_ready, req0_ready}); end
    step();
    req0_valid = 1'b0; req0_a = 16'h1234; req0_opcode = 4'b0001;
    #1;
    checks++; if (alu_opcode !== 4'h0 || alu_in1 !== 16'h7FFF || alu_in2 !== 16'h0001) begin errors++; $display("FAIL add_exec got=%h %h %h exp=0 7fff 0001", alu_opcode, alu_in1, alu_in2); end
    checks++; if (rsp_valid !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL add_exec_ctl got=%b%b%b exp=000", rsp_valid, req0_ready, req1_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 16'h8000) begin errors++; $display("FAIL add_rsp got=%b/%b/%h exp=1/0/8000", rsp_valid, rsp_id, rsp_data); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b101) begin errors++; $display("FAIL add_flags got=%b exp=101", {flag_n, flag_z, flag_v}); end
    checks++; if (alu_opcode !== 4'hF) begin errors++; $display("FAIL add_resp_alu got=%h exp=f", alu_opcode); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_done got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_xor();
    req1_opcode = 4'b0010; req1_a = 16'h00FF; req1_b = 16'h00FF; req1_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL xor_ready got=%b exp=10", {req1_ready, req0_ready}); end
    step();
    req1_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h0000) begin errors++; $display("FAIL xor_rsp got=%b/%b/%h exp=1/1/0000", rsp_valid, rsp_id, rsp_data); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b111) begin errors++; $display("FAIL xor_flags got=%b exp=111", {flag_n, flag_z, flag_v}); end
    step();
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_data;
    rst = 1'b1; step(); rst = 1'b0;
    req0_opcode = 4'b1010; req0_a = 16'hAB00; req0_b = 16'h0012;
    req1_opcode = 4'b1010; req1_a = 16'hCD00; req1_b = 16'h0034;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_data = (k % 2 == 0) ? 16'hAB12 : 16'hCD34;
      checks++;
      if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      step(); step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== k[0] || rsp_data !== exp_data) begin
        errors++; $display("FAIL rr_rsp%0d got=%b/%b/%h exp=1/%b/%h", k, rsp_valid, rsp_id, rsp_data, k[0], exp_data);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin errors++; $display("FAIL rr_flags got=%b exp=000", {flag_n, flag_z, flag_v}); end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    req0_opcode = 4'b0000; req0_a = 16'h0001; req0_b = 16'h0001; req0_valid = 1'b1;
    req1_opcode = 4'b0001; req1_a = 16'h0005; req1_b = 16'h0007; req1_valid = 1'b1;
    rsp_ready = 1'b0;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL bp_grant0 got=%b exp=01", {req1_ready, req0_ready}); end
    step();
    req0_valid = 1'b0;
    step();
    held = rsp_data;
    checks++; if (held !== 16'h0002) begin errors++; $display("FAIL bp_data got=%h exp=0002", held); end
    for (int i = 0; i < 5; i++) begin
      req0_valid = (i % 2 == 0); req1_a = 16'h0005 + 16'(i);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_id !== 1'b0 || {req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b%b exp=1/%h/0/00", i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, held);
      end
      step();
    end
    req0_valid = 1'b1; req1_a = 16'h0005;
    rsp_ready = 1'b1;
    step();
    checks++; if ({req1_ready, req0_ready} !== 2'b10 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after got=%b/%b exp=10/0", {req1_ready, req0_ready}, rsp_valid); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    checks++; if (rsp_data !== 16'hFFFE || rsp_id !== 1'b1) begin errors++; $display("FAIL bp_sub got=%h/%b exp=fffe/1", rsp_data, rsp_id); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b100) begin errors++; $display("FAIL bp_flags got=%b exp=100", {flag_n, flag_z, flag_v}); end
    step();
  endtask

  task automatic test_reset_exec();
    req0_opcode = 4'b0001; req0_a = 16'h0003; req0_b = 16'h0003; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rx_ready got=%b exp=1", req0_ready); end
    step();
    req0_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000 || rsp_valid !== 1'b0 || alu_opcode !== 4'hF) begin
      errors++; $display("FAIL rx_abort got=%b/%b/%h exp=000/0/f", {flag_n, flag_z, flag_v}, rsp_valid, alu_opcode);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || {flag_n, flag_z, flag_v} !== 3'b000) begin
        errors++; $display("FAIL rx_idle%0d got=%b/%b exp=0/000", i, rsp_valid, {flag_n, flag_z, flag_v});
      end
    end
  endtask

  task automatic test_llb();
    req0_opcode = 4'b0000; req0_a = 16'h8000; req0_b = 16'h8000; req0_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    checks++; if (rsp_data !== 16'h0000 || {flag_n, flag_z, flag_v} !== 3'b011) begin errors++; $display("FAIL llb_pre got=%h/%b exp=0000/011", rsp_data, {flag_n, flag_z, flag_v}); end
    step();
    req0_opcode = 4'b1010; req0_a = 16'h5500; req0_b = 16'h00AA; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h55AA) begin errors++; $display("FAIL llb_rsp got=%b/%h exp=1/55aa", rsp_valid, rsp_data); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b011) begin errors++; $display("FAIL llb_flags got=%b exp=011", {flag_n, flag_z, flag_v}); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_xor();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    test_llb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
